// File: rtl/stream_in_node.sv
// Input-stream source: clamps host words to +/-999 and queues them in a circular FIFO
// behind a registered output stage that feeds the neighbouring node's up input.
module stream_in_node #(
   parameter int DEPTH  = 39,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [15:0]       wr_data,
   output logic              full,
   output logic              overflow,
   output logic [ADDR_W:0]   count,
   output logic [10:0]       down_out_data,
   output logic              down_out_ready,
   input  logic              down_in_read
);

   localparam int                 FIFO_N   = DEPTH - 1;
   localparam logic [ADDR_W:0]    DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0]  PTR_LAST = ADDR_W'(DEPTH - 2);
   localparam logic signed [15:0] MAX_V    = 16'sd999;
   localparam logic signed [15:0] MIN_V    = -16'sd999;

   logic [10:0]       mem [FIFO_N];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] fifo_cnt;
   logic [10:0]       clamped;
   logic              consume;
   logic              accept;
   logic              stage_free;
   logic              fifo_empty;
   logic              load_fifo;
   logic              load_bypass;
   logic              fifo_push;
   logic              fifo_pop;

   function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      clamped = wr_data[10:0];
      if ($signed(wr_data) > MAX_V)
         clamped = MAX_V[10:0];
      else if ($signed(wr_data) < MIN_V)
         clamped = MIN_V[10:0];
   end

   assign count       = {1'b0, fifo_cnt} + {{ADDR_W{1'b0}}, down_out_ready};
   assign full        = (count == DEPTH_C);
   assign consume     = down_in_read & down_out_ready;
   assign accept      = wr_en & ((count < DEPTH_C) | consume);
   assign stage_free  = ~down_out_ready | consume;
   assign fifo_empty  = (fifo_cnt == '0);
   assign load_fifo   = stage_free & ~fifo_empty;
   // Bypass only when nothing is queued, so ordering is preserved.
   assign load_bypass = stage_free & fifo_empty & accept;
   assign fifo_push   = accept & ~load_bypass;
   assign fifo_pop    = load_fifo;

   always_ff @(posedge clk) begin
      if (fifo_push)
         mem[wr_ptr] <= clamped;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_cnt       <= '0;
         down_out_data  <= '0;
         down_out_ready <= 1'b0;
         overflow       <= 1'b0;
      end else begin
         if (fifo_push)
            wr_ptr <= next_ptr(wr_ptr);
         if (fifo_pop)
            rd_ptr <= next_ptr(rd_ptr);
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         // At full with a simultaneous push and pop, rd_ptr == wr_ptr and the
         // head is read before the slot is overwritten on the same edge.
         if (load_fifo) begin
            down_out_data  <= mem[rd_ptr];
            down_out_ready <= 1'b1;
         end else if (load_bypass) begin
            down_out_data  <= clamped;
            down_out_ready <= 1'b1;
         end else if (consume) begin
            down_out_ready <= 1'b0;
         end
         if (wr_en & ~accept)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_in_node.sv
// Directed bench for stream_in_node: a vector table for the basic flow plus
// hand-written sequences for fill/overflow, mid-stream reset and pointer wrap.
module tb_stream_in_node;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        full;
   logic        overflow;
   logic [6:0]  count;
   logic [10:0] down_out_data;
   logic        down_out_ready;
   logic        down_in_read;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic wr;
      int   data;
      logic rd;
      logic rdy;
      int   exp;
      int   cnt;
      logic ovf;
   } vec_t;

   vec_t vecs[$];
   int   exp_q[$];

   stream_in_node #(.DEPTH(39), .ADDR_W(6)) dut (
      .clk            (clk),
      .reset          (reset),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .full           (full),
      .overflow       (overflow),
      .count          (count),
      .down_out_data  (down_out_data),
      .down_out_ready (down_out_ready),
      .down_in_read   (down_in_read)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic add(input logic wr, input int data, input logic rd, input logic rdy,
                      input int exp, input int cnt);
      vec_t v;
      v.wr = wr; v.data = data; v.rd = rd; v.rdy = rdy; v.exp = exp; v.cnt = cnt; v.ovf = 1'b0;
      vecs.push_back(v);
   endtask

   task automatic step(input logic wr, input int data, input logic rd);
      wr_en        = wr;
      wr_data      = 16'(data);
      down_in_read = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_data = '0; down_in_read = 1'b0;

      //      wr data   rd rdy exp   cnt
      add(1, 5,     0, 1, 5,    1);
      add(1, 12,    0, 1, 5,    2);
      add(1, -7,    0, 1, 5,    3);
      add(0, 0,     1, 1, 12,   2);
      add(0, 0,     1, 1, -7,   1);
      add(0, 0,     1, 0, 0,    0);
      add(1, 1500,  0, 1, 999,  1);
      add(1, -2000, 0, 1, 999,  2);
      add(1, 999,   0, 1, 999,  3);
      add(1, -999,  0, 1, 999,  4);
      add(0, 0,     1, 1, -999, 3);
      add(0, 0,     1, 1, 999,  2);
      add(0, 0,     1, 1, -999, 1);
      add(0, 0,     1, 0, 0,    0);
      add(1, 7,     1, 1, 7,    1);
      add(1, 8,     1, 1, 8,    1);
      add(1, 1000,  0, 1, 8,    2);
      add(1, -1000, 1, 1, 999,  2);
      add(1, 0,     1, 1, -999, 2);
      add(0, 0,     1, 1, 0,    1);
      add(0, 0,     1, 0, 0,    0);
      add(1, -1,    0, 1, -1,   1);
      add(0, 0,     1, 0, 0,    0);

      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", down_out_ready, 0);
      check("reset_data",  down_out_data,  0);
      check("reset_count", count,          0);
      check("reset_full",  full,           0);
      check("reset_ovf",   overflow,       0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         step(vecs[i].wr, vecs[i].data, vecs[i].rd);
         check($sformatf("vec%0d_ready", i), down_out_ready, vecs[i].rdy);
         check($sformatf("vec%0d_count", i), count, vecs[i].cnt);
         check($sformatf("vec%0d_full", i), full, (vecs[i].cnt == 39) ? 1 : 0);
         check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
         if (vecs[i].rdy)
            check($sformatf("vec%0d_data", i), $signed(down_out_data), vecs[i].exp);
      end

      // Fill to capacity, write+read at full, then a dropped write.
      for (int i = 0; i < 39; i++) step(1, i, 0);
      check("fill_count", count, 39);
      check("fill_full",  full, 1);
      check("fill_ovf",   overflow, 0);
      check("fill_head",  $signed(down_out_data), 0);
      step(1, 40, 1);
      check("wr_rd_full_count", count, 39);
      check("wr_rd_full_ovf",   overflow, 0);
      check("wr_rd_full_head",  $signed(down_out_data), 1);
      step(1, 77, 0);
      check("drop_count", count, 39);
      check("drop_full",  full, 1);
      check("drop_ovf",   overflow, 1);
      for (int i = 1; i <= 38; i++) exp_q.push_back(i);
      exp_q.push_back(40);
      foreach (exp_q[k]) begin
         check($sformatf("drain%0d_ready", k), down_out_ready, 1);
         check($sformatf("drain%0d_data", k), $signed(down_out_data), exp_q[k]);
         step(0, 0, 1);
      end
      check("drain_end_ready", down_out_ready, 0);
      check("drain_end_count", count, 0);
      check("drain_ovf_sticky", overflow, 1);
      down_in_read = 1'b0;

      // Mid-stream asynchronous reset.
      for (int i = 0; i < 20; i++) step(1, 100 + i, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1);
      check("pre_reset_count", count, 10);
      check("pre_reset_data",  $signed(down_out_data), 110);
      wr_en = 1'b0; down_in_read = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async_rst_ready", down_out_ready, 0);
      check("async_rst_data",  down_out_data, 0);
      check("async_rst_count", count, 0);
      check("async_rst_full",  full, 0);
      check("async_rst_ovf",   overflow, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      step(1, 3, 0);
      check("restart_ready", down_out_ready, 1);
      check("restart_data",  $signed(down_out_data), 3);
      check("restart_count", count, 1);
      step(0, 0, 1);
      check("restart_empty", count, 0);

      // Pointer wrap: keep five words queued while streaming 0..99 through.
      for (int i = 0; i < 5; i++) step(1, i, 0);
      check("wrap_pre_count", count, 5);
      check("wrap_pre_data",  $signed(down_out_data), 0);
      for (int i = 5; i < 100; i++) begin
         step(1, i, 1);
         check($sformatf("wrap%0d_data", i), $signed(down_out_data), i - 4);
         check($sformatf("wrap%0d_count", i), count, 5);
      end
      for (int i = 96; i < 100; i++) begin
         step(0, 0, 1);
         check($sformatf("wrap_tail%0d", i), $signed(down_out_data), i);
      end
      step(0, 0, 1);
      check("wrap_end_ready", down_out_ready, 0);
      check("wrap_end_count", count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
